// File: rtl/lut_neuron_stream.sv
// rtl/lut_neuron_stream.sv - run-time loadable LUT neuron with valid/ready streaming lookup
// The table is filled sequentially in LOAD, served in RUN, and emptied in DRAIN before a reload.
module lut_neuron_stream #(
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int PIPE_STAGES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_start,
  output logic                cfg_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data,
  output logic [1:0]          mode
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  state_t               state, state_nx;
  logic [IN_BITS-1:0]   ptr;
  logic [OUT_BITS-1:0]  tbl [DEPTH];
  logic                 pipe_busy;
  logic                 out_free;
  logic                 accept;

  assign mode      = state;
  assign cfg_ready = (state == ST_LOAD);
  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_LOAD) begin
        if (cfg_we) ptr <= ptr + IN_BITS'(1);
      end else begin
        ptr <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD:  if (cfg_we && (&ptr)) state_nx = ST_RUN;
      ST_RUN:   if (cfg_start) state_nx = ST_DRAIN;
      ST_DRAIN: if (!pipe_busy) state_nx = ST_LOAD;
      default:  state_nx = ST_LOAD;
    endcase
  end

  // Table storage is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD && cfg_we) tbl[ptr] <= cfg_data;
  end

  generate
    if (PIPE_STAGES == 2) begin : g_pipe2
      logic               a_valid;
      logic [IN_BITS-1:0] a_addr;
      logic               a_free;

      assign a_free    = !a_valid || out_free;
      assign in_ready  = (state == ST_RUN) && a_free;
      assign pipe_busy = a_valid || out_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_valid   <= 1'b0;
          a_addr    <= '0;
          out_valid <= 1'b0;
          out_data  <= '0;
        end else begin
          if (a_free) begin
            a_valid <= accept;
            if (accept) a_addr <= in_data;
          end
          if (out_free) begin
            out_valid <= a_valid;
            if (a_valid) out_data <= tbl[a_addr];
          end
        end
      end
    end else begin : g_pipe1
      assign in_ready  = (state == ST_RUN) && out_free;
      assign pipe_busy = out_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (out_free) begin
          out_valid <= accept;
          if (accept) out_data <= tbl[in_data];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_lut_neuron_stream.sv
// tb/tb_lut_neuron_stream.sv - directed bench for lut_neuron_stream, one- and two-stage pipelines
// Both variants share the config port; sel routes the stream handshake to one of them.
module tb_lut_neuron_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_data = 2'b00;
  logic       cfg_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = 6'd0;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;

  logic       cfg_ready1, in_ready1, out_valid1, cfg_ready2, in_ready2, out_valid2;
  logic [1:0] out_data1, mode1, out_data2, mode2;
  logic       cfg_ready, in_ready, out_valid;
  logic [1:0] out_data, mode;

  logic [1:0] mdl [64];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  lut_neuron_stream #(.IN_BITS(6), .OUT_BITS(2), .PIPE_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_data(cfg_data), .cfg_start(cfg_start),
    .cfg_ready(cfg_ready1), .in_valid(in_valid && !sel), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready || sel), .out_data(out_data1), .mode(mode1));

  lut_neuron_stream #(.IN_BITS(6), .OUT_BITS(2), .PIPE_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_data(cfg_data), .cfg_start(cfg_start),
    .cfg_ready(cfg_ready2), .in_valid(in_valid && sel), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready || !sel), .out_data(out_data2), .mode(mode2));

  assign cfg_ready = sel ? cfg_ready2 : cfg_ready1;
  assign in_ready  = sel ? in_ready2  : in_ready1;
  assign out_valid = sel ? out_valid2 : out_valid1;
  assign out_data  = sel ? out_data2  : out_data1;
  assign mode      = sel ? mode2      : mode1;

  // inv=0 loads a[1:0]^a[5:4]; inv=1 loads ~a[1:0]
  task automatic load_table(input bit inv);
    logic [5:0] a;
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      mdl[i] = inv ? ~a[1:0] : (a[1:0] ^ a[5:4]);
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_data = mdl[i];
      cfg_start = (i == 5);
      #1;
      checks++;
      if (mode !== 2'b00 || cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_mode[%0d]: mode=%b cfg_ready=%b, required mode=00 cfg_ready=1", i, mode, cfg_ready);
      end
    end
    @(negedge clk);
    cfg_we = 1'b0;
    cfg_start = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b01 || cfg_ready !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_done: mode=%b cfg_ready=%b in_ready=%b, required 01 0 1", mode, cfg_ready, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mode1 !== 2'b00 || cfg_ready1 !== 1'b1 || in_ready1 !== 1'b0 || out_valid1 !== 1'b0 || out_data1 !== 2'b00 ||
        mode2 !== 2'b00 || cfg_ready2 !== 1'b1 || in_ready2 !== 1'b0 || out_valid2 !== 1'b0 || out_data2 !== 2'b00) begin
      errors++;
      $display("FAIL reset: mode=%b/%b cfg_ready=%b/%b in_ready=%b/%b out_valid=%b/%b out_data=%b/%b, required 00 1 0 0 00",
               mode1, mode2, cfg_ready1, cfg_ready2, in_ready1, in_ready2, out_valid1, out_valid2, out_data1, out_data2);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream(input int lat);
    logic [1:0] expv;
    for (int k = 0; k < 64 + lat; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = (k < 64);
      in_data = 6'(k);
      #1;
      if (k < 64) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready[%0d]: got %b, required 1", k, in_ready);
        end
      end
      checks++;
      if (k < lat) begin
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_latency[%0d]: out_valid=%b, required 0", k, out_valid);
        end
      end else begin
        expv = mdl[k - lat];
        if (out_valid !== 1'b1 || out_data !== expv) begin
          errors++;
          $display("FAIL stream_data[a=%0d]: out_valid=%b out_data=%b, required 1 %b", k - lat, out_valid, out_data, expv);
        end
        if (k - lat == 13) begin
          checks++;
          if (out_data !== 2'b01) begin
            errors++;
            $display("FAIL stream_a13: got %b, required 01", out_data);
          end
        end
        if (k - lat == 63) begin
          checks++;
          if (out_data !== 2'b00) begin
            errors++;
            $display("FAIL stream_a63: got %b, required 00", out_data);
          end
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_empty: out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [5:0] q [$];
    logic [5:0] a;
    logic [1:0] held;
    bit         was_held = 0;
    int         idx = 0;
    int         rcv = 0;
    int         cyc = 0;
    while (rcv < 20 && cyc < 200) begin
      @(negedge clk);
      in_valid = (idx < 20);
      in_data = 6'((idx * 7 + 3) % 64);
      out_ready = !(cyc >= 5 && cyc < 10);
      #1;
      if (was_held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          errors++;
          $display("FAIL bp_hold[cyc %0d]: out_valid=%b out_data=%b, required 1 %b", cyc, out_valid, out_data, held);
        end
      end
      if (cyc >= 7 && cyc < 10) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready[cyc %0d]: got %b, required 0", cyc, in_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_dup: out_data=%b with nothing outstanding", out_data);
        end else begin
          a = q.pop_front();
          if (out_data !== mdl[a]) begin
            errors++;
            $display("FAIL bp_order[a=%0d]: got %b, required %b", a, out_data, mdl[a]);
          end
        end
        rcv++;
      end
      was_held = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        idx++;
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (rcv != 20 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: received %0d out_valid=%b, required 20 and 0", rcv, out_valid);
    end
  endtask

  task automatic lookup(input logic [5:0] a, input logic [1:0] expv, input string name);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = a;
    out_ready = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== expv) begin
      errors++;
      $display("FAIL %s: out_valid=%b out_data=%b, required 1 %b", name, out_valid, out_data, expv);
    end
  endtask

  task automatic test_drain_reload();
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 6'd13;
    out_ready = 1'b0;
    cfg_start = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_accept: in_ready=%b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    cfg_start = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b10 || out_valid !== 1'b1 || out_data !== 2'b01 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_state: mode=%b out_valid=%b out_data=%b in_ready=%b, required 10 1 01 0",
               mode, out_valid, out_data, in_ready);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    while (mode !== 2'b00 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (mode !== 2'b00 || cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_done: mode=%b cfg_ready=%b out_valid=%b, required 00 1 0", mode, cfg_ready, out_valid);
    end
    load_table(1'b1);
    lookup(6'd0, 2'b11, "reload_a0");
    lookup(6'd63, 2'b00, "reload_a63");
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_data = 2'b10;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b00 || cfg_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: mode=%b cfg_ready=%b out_valid=%b, required 00 1 0", mode, cfg_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_table(1'b0);
    lookup(6'b001101, 2'b01, "midload_a13");
    lookup(6'b100110, 2'b00, "midload_a38");
  endtask

  task automatic test_pipe2();
    sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cfg_we = 1'b1;
      cfg_data = 2'b11;
    end
    @(negedge clk);
    cfg_we = 1'b0;
    #1;
    checks++;
    if (mode !== 2'b01) begin
      errors++;
      $display("FAIL pipe2_mode: got %b, required 01", mode);
    end
    test_stream(2);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    load_table(1'b0);
    test_stream(1);
    test_backpressure();
    test_drain_reload();
    test_reset_midload();
    test_pipe2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
